// File: rtl/bus_arb_pkg.sv
// Shared encodings for the two-port CPU bus arbiter: FSM states,
// transfer direction and requester port numbering.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

endpackage

// File: rtl/bus_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes
// to the port that did not win last time.
module rr_pick2
  import bus_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = PORT_FETCH;
    if (&req) begin
      grant_idx = ~last_grant;
    end else if (req[1]) begin
      grant_idx = PORT_DATA;
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one memory bus between instruction fetch (port 0) and data (port 1),
// with one outstanding transaction at a time and an optional timeout abort.
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0_valid,
  input  logic                  req0_mode,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic                  req1_mode,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_ready,
  output logic                  resp0_valid,
  output logic                  resp1_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] BUS_addr,
  output logic [DATA_WIDTH-1:0] BUS_wdata,
  input  logic [DATA_WIDTH-1:0] BUS_rdata,
  output logic                  BUS_valid,
  input  logic                  BUS_wready,
  output logic                  BUS_rready,
  input  logic                  BUS_rvalid,
  output logic                  BUS_mode
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  arb_state_t            state_q, state_d;
  logic                  owner_q, owner_d;
  logic                  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  mode_q, mode_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic grant_valid;
  logic grant_idx;
  logic done;

  rr_pick2 u_pick (
    .req         ({req1_valid, req0_valid}),
    .last_grant  (last_grant_q),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  // The handshake that finishes a transfer depends on its direction.
  assign done = (mode_q == MODE_WRITE) ? BUS_wready : BUS_rvalid;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    mode_d       = mode_q;
    rdata_d      = rdata_q;
    err_d        = err_q;

    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          owner_d = grant_idx;
          cnt_d   = '0;
          addr_d  = (grant_idx == PORT_DATA) ? req1_addr  : req0_addr;
          wdata_d = (grant_idx == PORT_DATA) ? req1_wdata : req0_wdata;
          mode_d  = (grant_idx == PORT_DATA) ? req1_mode  : req0_mode;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        // Completion takes priority over a timeout landing on the same cycle.
        if (done) begin
          rdata_d = (mode_q == MODE_WRITE) ? '0 : BUS_rdata;
          err_d   = 1'b0;
          state_d = ST_RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST)) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_RESP: begin
        last_grant_d = owner_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      owner_q      <= PORT_FETCH;
      last_grant_q <= PORT_DATA;
      cnt_q        <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      mode_q       <= MODE_READ;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      mode_q       <= mode_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Ready is gated by reset so a held request never sees a grant during reset.
  assign req0_ready = rst_n && (state_q == ST_IDLE) && grant_valid && (grant_idx == PORT_FETCH);
  assign req1_ready = rst_n && (state_q == ST_IDLE) && grant_valid && (grant_idx == PORT_DATA);

  assign BUS_valid   = (state_q == ST_BUSY);
  assign BUS_rready  = BUS_valid && (mode_q == MODE_READ);
  assign BUS_addr    = addr_q;
  assign BUS_wdata   = wdata_q;
  assign BUS_mode    = mode_q;
  assign resp0_valid = (state_q == ST_RESP) && (owner_q == PORT_FETCH);
  assign resp1_valid = (state_q == ST_RESP) && (owner_q == PORT_DATA);
  assign resp_rdata  = rdata_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by random
// transactions, predicted by a transaction-level round-robin/timeout model.
module tb_bus_arbiter;

   localparam int TO = 4;

   logic        clk;
   logic        rst_n;
   logic        req0_valid, req0_mode, req0_ready;
   logic [31:0] req0_addr, req0_wdata;
   logic        req1_valid, req1_mode, req1_ready;
   logic [31:0] req1_addr, req1_wdata;
   logic        resp0_valid, resp1_valid, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] BUS_addr, BUS_wdata, BUS_rdata;
   logic        BUS_valid, BUS_wready, BUS_rready, BUS_rvalid, BUS_mode;

   // Requester view: what each port currently presents
   logic        pend[2];
   logic        modeA[2];
   logic [31:0] addrA[2];
   logic [31:0] wdataA[2];
   int          lastGrant;

   int compared;
   int mismatched;

   bus_arbiter #(
      .DATA_WIDTH(32),
      .ADDR_WIDTH(32),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .req0_valid(req0_valid),
      .req0_mode(req0_mode),
      .req0_addr(req0_addr),
      .req0_wdata(req0_wdata),
      .req0_ready(req0_ready),
      .req1_valid(req1_valid),
      .req1_mode(req1_mode),
      .req1_addr(req1_addr),
      .req1_wdata(req1_wdata),
      .req1_ready(req1_ready),
      .resp0_valid(resp0_valid),
      .resp1_valid(resp1_valid),
      .resp_rdata(resp_rdata),
      .resp_err(resp_err),
      .BUS_addr(BUS_addr),
      .BUS_wdata(BUS_wdata),
      .BUS_rdata(BUS_rdata),
      .BUS_valid(BUS_valid),
      .BUS_wready(BUS_wready),
      .BUS_rready(BUS_rready),
      .BUS_rvalid(BUS_rvalid),
      .BUS_mode(BUS_mode)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Push the requester arrays onto the DUT request pins
   task automatic applyStimulus();
      req0_valid = pend[0];
      req0_mode  = modeA[0];
      req0_addr  = addrA[0];
      req0_wdata = wdataA[0];
      req1_valid = pend[1];
      req1_mode  = modeA[1];
      req1_addr  = addrA[1];
      req1_wdata = wdataA[1];
   endtask

   task automatic setRequest(input int p, input logic m, input logic [31:0] a, input logic [31:0] d);
      pend[p]   = 1'b1;
      modeA[p]  = m;
      addrA[p]  = a;
      wdataA[p] = d;
   endtask

   task automatic randomRequest(input int p);
      setRequest(p, 1'($urandom_range(0, 1)), $urandom, $urandom);
   endtask

   // Reference arbitration rule: lone requester wins, a tie alternates
   function automatic int pickPort();
      if (pend[0] && pend[1]) return 1 - lastGrant;
      else if (pend[0]) return 0;
      else return 1;
   endfunction

   // Idle cycles with junk handshakes that must be ignored
   task automatic strayIdle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         applyStimulus();
         BUS_rvalid = 1'($urandom_range(0, 1));
         BUS_wready = 1'($urandom_range(0, 1));
         BUS_rdata  = $urandom;
         @(negedge clk);
         checkOutput("stray_bus_valid", 64'(BUS_valid), 64'(0));
         checkOutput("stray_resp0", 64'(resp0_valid), 64'(0));
         checkOutput("stray_resp1", 64'(resp1_valid), 64'(0));
      end
      BUS_rvalid = 1'b0;
      BUS_wready = 1'b0;
   endtask

   // One full transaction: grant cycle, BUSY cycles, RESP cycle.
   // delay = number of BUSY cycles before the slave handshakes.
   task automatic runTxn(input int delay, input logic [31:0] slaveData, input bit rearm);
      int          p;
      int          busyCycles;
      bit          expErr;
      logic        lMode;
      logic [31:0] lAddr, lWdata, expRdata;

      @(posedge clk); #1;
      applyStimulus();
      BUS_rvalid = 1'b0;
      BUS_wready = 1'b0;
      BUS_rdata  = $urandom;
      @(negedge clk);
      p = pickPort();
      checkOutput("grant_ready0", 64'(req0_ready), 64'(p == 0));
      checkOutput("grant_ready1", 64'(req1_ready), 64'(p == 1));
      checkOutput("grant_bus_valid", 64'(BUS_valid), 64'(0));

      lMode      = modeA[p];
      lAddr      = addrA[p];
      lWdata     = wdataA[p];
      expErr     = (delay >= TO);
      busyCycles = expErr ? TO : delay + 1;
      expRdata   = (expErr || lMode) ? 32'h0 : slaveData;

      for (int k = 0; k < busyCycles; k++) begin
         @(posedge clk); #1;
         if (k == 0) begin
            if (rearm) randomRequest(p);
            else pend[p] = 1'b0;
            applyStimulus();
         end
         BUS_rdata  = (k == delay) ? slaveData : $urandom;
         BUS_rvalid = lMode ? 1'($urandom_range(0, 1)) : 1'(k == delay);
         BUS_wready = lMode ? 1'(k == delay) : 1'($urandom_range(0, 1));
         @(negedge clk);
         checkOutput("busy_valid", 64'(BUS_valid), 64'(1));
         checkOutput("busy_addr", 64'(BUS_addr), 64'(lAddr));
         checkOutput("busy_wdata", 64'(BUS_wdata), 64'(lWdata));
         checkOutput("busy_mode", 64'(BUS_mode), 64'(lMode));
         checkOutput("busy_rready", 64'(BUS_rready), 64'(!lMode));
         checkOutput("busy_resp", 64'({resp1_valid, resp0_valid}), 64'(0));
         checkOutput("busy_ready", 64'({req1_ready, req0_ready}), 64'(0));
      end

      @(posedge clk); #1;
      BUS_rvalid = 1'($urandom_range(0, 1));
      BUS_wready = 1'($urandom_range(0, 1));
      BUS_rdata  = $urandom;
      @(negedge clk);
      checkOutput("resp_bus_valid", 64'(BUS_valid), 64'(0));
      checkOutput("resp_rready", 64'(BUS_rready), 64'(0));
      checkOutput("resp0_valid", 64'(resp0_valid), 64'(p == 0));
      checkOutput("resp1_valid", 64'(resp1_valid), 64'(p == 1));
      checkOutput("resp_rdata", 64'(resp_rdata), 64'(expRdata));
      checkOutput("resp_err", 64'(resp_err), 64'(expErr));
      checkOutput("resp_ready", 64'({req1_ready, req0_ready}), 64'(0));
      lastGrant = p;
   endtask

   // Asynchronous reset: every output must drop immediately
   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_bus_valid"}, 64'(BUS_valid), 64'(0));
      checkOutput({tag, "_bus_addr"}, 64'(BUS_addr), 64'(0));
      checkOutput({tag, "_bus_wdata"}, 64'(BUS_wdata), 64'(0));
      checkOutput({tag, "_bus_mode"}, 64'(BUS_mode), 64'(0));
      checkOutput({tag, "_bus_rready"}, 64'(BUS_rready), 64'(0));
      checkOutput({tag, "_resp"}, 64'({resp1_valid, resp0_valid}), 64'(0));
      checkOutput({tag, "_rdata"}, 64'(resp_rdata), 64'(0));
      checkOutput({tag, "_err"}, 64'(resp_err), 64'(0));
      checkOutput({tag, "_ready"}, 64'({req1_ready, req0_ready}), 64'(0));
   endtask

   // Directed scenarios first, then a random transaction mix
   initial begin
      compared   = 0;
      mismatched = 0;
      lastGrant  = 1;
      for (int i = 0; i < 2; i++) begin
         pend[i] = 1'b0; modeA[i] = 1'b0; addrA[i] = '0; wdataA[i] = '0;
      end
      rst_n      = 1'b0;
      BUS_rvalid = 1'b0;
      BUS_wready = 1'b0;
      BUS_rdata  = '0;
      applyStimulus();
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #2;
      checkResetOutputs("reset");
      repeat (2) @(posedge clk);
      #1;
      applyStimulus();
      rst_n = 1'b1;

      $display("[TB] single read on port 0");
      setRequest(0, 1'b0, 32'h100, 32'h0);
      runTxn(1, 32'hDEADBEEF, 1'b0);

      $display("[TB] stray handshakes while idle");
      strayIdle(3);

      $display("[TB] write with wait states on port 1");
      setRequest(1, 1'b1, 32'h2000, 32'h12345678);
      runTxn(2, 32'hA5A5A5A5, 1'b0);

      $display("[TB] timeout and last-cycle completion");
      setRequest(0, 1'b0, 32'h300, 32'h0);
      runTxn(100, 32'h11111111, 1'b0);
      setRequest(1, 1'b0, 32'h400, 32'h0);
      runTxn(TO - 1, 32'hCAFEF00D, 1'b0);

      $display("[TB] contention fairness");
      randomRequest(0);
      randomRequest(1);
      for (int i = 0; i < 4; i++) runTxn(0, $urandom, 1'b1);
      runTxn(0, $urandom, 1'b0);
      runTxn(0, $urandom, 1'b0);

      $display("[TB] reset during BUSY");
      setRequest(0, 1'b1, 32'h500, 32'h55AA55AA);
      @(posedge clk); #1;
      applyStimulus();
      @(negedge clk);
      checkOutput("rst_grant_ready0", 64'(req0_ready), 64'(1));
      @(posedge clk); #1;
      randomRequest(0);
      randomRequest(1);
      applyStimulus();
      @(negedge clk);
      checkOutput("rst_busy_valid", 64'(BUS_valid), 64'(1));
      #2 rst_n = 1'b0;
      #1 checkResetOutputs("midreset");
      @(negedge clk);
      checkOutput("midreset_hold_resp", 64'({resp1_valid, resp0_valid}), 64'(0));
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rst_n      = 1'b1;
      lastGrant  = 1;
      runTxn(0, 32'h0BADC0DE, 1'b0);
      runTxn(1, 32'h600DF00D, 1'b0);

      $display("[TB] random transactions");
      for (int i = 0; i < 40; i++) begin
         if (!pend[0] && !pend[1]) begin
            if ($urandom_range(0, 2) == 0) strayIdle($urandom_range(1, 3));
            case ($urandom_range(0, 2))
               0: randomRequest(0);
               1: randomRequest(1);
               default: begin randomRequest(0); randomRequest(1); end
            endcase
         end else begin
            for (int j = 0; j < 2; j++)
               if (!pend[j] && $urandom_range(0, 1) == 1) randomRequest(j);
         end
         runTxn($urandom_range(0, 5), $urandom, 1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
